// File: rtl/fir_coef_loader_if.sv
// Bundle of the coefficient-source handshake and the fir_filter write port
// seen by fir_coef_loader; state_dbg exposes the loader FSM for checkers.
interface fir_coef_loader_if #(
  parameter int AW = 11,
  parameter int CW = 20
);
  // Handshake: a word on coef_in transfers at a rising edge where
  // coef_valid and coef_ready are both 1; either side may idle otherwise.
  logic          start;
  logic          abort;
  logic [CW-1:0] coef_in;
  logic          coef_valid;
  logic          coef_ready;
  logic [CW-1:0] CIN;
  logic [AW-1:0] CADDR;
  logic          CLOAD;
  logic          busy;
  logic          done;
  logic          run_en;
  logic [1:0]    state_dbg;

  modport master (
    output start, abort, coef_in, coef_valid,
    input  coef_ready, CIN, CADDR, CLOAD, busy, done, run_en, state_dbg
  );

  modport slave (
    input  start, abort, coef_in, coef_valid,
    output coef_ready, CIN, CADDR, CLOAD, busy, done, run_en, state_dbg
  );
endinterface

// File: rtl/fir_coef_loader.sv
// Streams NTAPS coefficients from a valid/ready source into the fir_filter
// write port (CIN/CADDR/CLOAD) and raises run_en once the final tap lands.
module fir_coef_loader #(
  parameter int NTAPS = 2048,
  parameter int AW    = 11,
  parameter int CW    = 20
) (
  input  logic               clk_slow,
  input  logic               resetn,
  fir_coef_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NTAPS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic [CW-1:0] cin_q, cin_d;
  logic          cload_q, cload_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          run_en_q, run_en_d;
  logic          accept;

  // ready_q is high exactly while in LOAD, so this also gates stray valids.
  assign accept = bus.coef_valid & ready_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cin_d   = cin_q;
    caddr_d = caddr_q;
    cload_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = LOAD;
          addr_d  = '0;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (accept) begin
          cin_d   = bus.coef_in;
          caddr_d = addr_q;
          cload_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = LAST;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      LAST: begin
        state_d = bus.abort ? IDLE : DONE;
        addr_d  = '0;
      end
      DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = LOAD;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase

    // Status outputs are registered copies of the state being entered.
    ready_d  = (state_d == LOAD);
    busy_d   = (state_d == LOAD) || (state_d == LAST);
    done_d   = (state_d == DONE);
    run_en_d = (state_d == DONE);
  end

  always_ff @(posedge clk_slow) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cin_q    <= '0;
      caddr_q  <= '0;
      cload_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      run_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cin_q    <= cin_d;
      caddr_q  <= caddr_d;
      cload_q  <= cload_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      run_en_q <= run_en_d;
    end
  end

  assign bus.coef_ready = ready_q;
  assign bus.CIN        = cin_q;
  assign bus.CADDR      = caddr_q;
  assign bus.CLOAD      = cload_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.run_en     = run_en_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: a 2048-tap instance for reset and the
// full load, an 8-tap instance for bubbles, abort, restart and mid-load reset.
module tb_fir_coef_loader;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic clk_slow = 1'b0;
  logic resetn   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_slow = ~clk_slow;

  fir_coef_loader_if #(.AW(11), .CW(20)) big_if ();
  fir_coef_loader_if #(.AW(3),  .CW(20)) sm_if ();

  fir_coef_loader #(.NTAPS(2048), .AW(11), .CW(20)) dut_big (
    .clk_slow (clk_slow),
    .resetn   (resetn),
    .bus      (big_if.slave)
  );

  fir_coef_loader #(.NTAPS(8), .AW(3), .CW(20)) dut_sm (
    .clk_slow (clk_slow),
    .resetn   (resetn),
    .bus      (sm_if.slave)
  );

  task automatic step();
    @(posedge clk_slow);
    #1;
  endtask

  task automatic init_inputs();
    big_if.start = 1'b0; big_if.abort = 1'b0; big_if.coef_valid = 1'b0; big_if.coef_in = '0;
    sm_if.start  = 1'b0; sm_if.abort  = 1'b0; sm_if.coef_valid  = 1'b0; sm_if.coef_in  = '0;
  endtask

  // Drives a complete 8-word load on the small instance, ending in DONE.
  task automatic load_small(input logic [19:0] base);
    sm_if.start = 1'b1;
    step();
    sm_if.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sm_if.coef_valid = 1'b1;
      sm_if.coef_in    = base + 20'(k);
      step();
    end
    sm_if.coef_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    init_inputs();
    resetn = 1'b0;
    big_if.coef_valid = 1'b1;
    sm_if.coef_valid  = 1'b1;
    step();
    step();
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({big_if.coef_ready, big_if.CLOAD, big_if.busy, big_if.done, big_if.run_en} !== 5'b0) begin
        failures++;
        $display("FAIL reset_big_flags cyc=%0d got=%b exp=00000", c,
                 {big_if.coef_ready, big_if.CLOAD, big_if.busy, big_if.done, big_if.run_en});
      end
      checks++;
      if (big_if.CADDR !== 11'd0 || big_if.CIN !== 20'd0 || big_if.state_dbg !== ST_IDLE) begin
        failures++;
        $display("FAIL reset_big_regs cyc=%0d caddr=%0d cin=%0h state=%0d exp=0/0/0", c,
                 big_if.CADDR, big_if.CIN, big_if.state_dbg);
      end
      checks++;
      if ({sm_if.coef_ready, sm_if.CLOAD, sm_if.busy, sm_if.done, sm_if.run_en} !== 5'b0 ||
          sm_if.state_dbg !== ST_IDLE) begin
        failures++;
        $display("FAIL reset_sm cyc=%0d flags=%b state=%0d exp=00000/0", c,
                 {sm_if.coef_ready, sm_if.CLOAD, sm_if.busy, sm_if.done, sm_if.run_en}, sm_if.state_dbg);
      end
    end
    big_if.coef_valid = 1'b0;
    sm_if.coef_valid  = 1'b0;
  endtask

  task automatic test_full_load();
    int cload_cnt;
    int steps;
    bit seen_done;
    cload_cnt = 0;
    big_if.start = 1'b1;
    step();
    big_if.start = 1'b0;
    steps = 0;
    checks++;
    if (big_if.coef_ready !== 1'b1 || big_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL full_start ready=%b busy=%b exp=1/1", big_if.coef_ready, big_if.busy);
    end
    for (int k = 0; k < 2048; k++) begin
      big_if.coef_valid = 1'b1;
      big_if.coef_in    = 20'(k);
      step();
      steps++;
      if (big_if.CLOAD === 1'b1) cload_cnt++;
      checks++;
      if (big_if.CLOAD !== 1'b1 || big_if.CADDR !== 11'(k) || big_if.CIN !== 20'(k)) begin
        failures++;
        $display("FAIL full_write k=%0d cload=%b caddr=%0d cin=%0d exp=1/%0d/%0d",
                 k, big_if.CLOAD, big_if.CADDR, big_if.CIN, k, k);
      end
    end
    checks++;
    if (big_if.state_dbg !== ST_LAST || big_if.done !== 1'b0 || big_if.coef_ready !== 1'b0 ||
        big_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL full_last state=%0d done=%b ready=%b busy=%b exp=2/0/0/1",
               big_if.state_dbg, big_if.done, big_if.coef_ready, big_if.busy);
    end
    seen_done = 1'b0;
    for (int w = 0; w < 10 && !seen_done; w++) begin
      step();
      steps++;
      if (big_if.CLOAD === 1'b1) cload_cnt++;
      if (big_if.done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done || (steps + 1) != 2050) begin
      failures++;
      $display("FAIL full_start_to_done got=%0d seen=%b exp=2050", steps + 1, seen_done);
    end
    checks++;
    if (big_if.run_en !== 1'b1 || big_if.busy !== 1'b0 || big_if.coef_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_done_flags run_en=%b busy=%b ready=%b exp=1/0/0",
               big_if.run_en, big_if.busy, big_if.coef_ready);
    end
    checks++;
    if (cload_cnt != 2048) begin
      failures++;
      $display("FAIL full_cload_count got=%0d exp=2048", cload_cnt);
    end
    big_if.coef_valid = 1'b0;
  endtask

  task automatic test_bubbled();
    logic [19:0] words [8];
    int k;
    bit v;
    for (int i = 0; i < 8; i++) words[i] = 20'h5A000 + 20'(i * 37);
    sm_if.start = 1'b1;
    step();
    sm_if.start = 1'b0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      v = (i % 2 == 0);
      sm_if.coef_valid = v;
      sm_if.coef_in    = v ? words[k] : 20'hFFFFF;
      sm_if.start      = (i == 5);
      step();
      sm_if.start = 1'b0;
      checks++;
      if (v) begin
        if (sm_if.CLOAD !== 1'b1 || sm_if.CADDR !== 3'(k) || sm_if.CIN !== words[k]) begin
          failures++;
          $display("FAIL bubble_write i=%0d cload=%b caddr=%0d cin=%0h exp=1/%0d/%0h",
                   i, sm_if.CLOAD, sm_if.CADDR, sm_if.CIN, k, words[k]);
        end
        k++;
      end else begin
        if (sm_if.CLOAD !== 1'b0 || sm_if.CADDR !== 3'(k - 1) || sm_if.CIN !== words[k-1]) begin
          failures++;
          $display("FAIL bubble_hold i=%0d cload=%b caddr=%0d cin=%0h exp=0/%0d/%0h",
                   i, sm_if.CLOAD, sm_if.CADDR, sm_if.CIN, k - 1, words[k-1]);
        end
      end
    end
    checks++;
    if (sm_if.done !== 1'b1 || sm_if.run_en !== 1'b1 || sm_if.busy !== 1'b0 ||
        sm_if.state_dbg !== ST_DONE) begin
      failures++;
      $display("FAIL bubble_done done=%b run_en=%b busy=%b state=%0d exp=1/1/0/3",
               sm_if.done, sm_if.run_en, sm_if.busy, sm_if.state_dbg);
    end
  endtask

  task automatic test_abort_mid_load();
    sm_if.start = 1'b1;
    step();
    sm_if.start = 1'b0;
    checks++;
    if (sm_if.done !== 1'b0 || sm_if.run_en !== 1'b0 || sm_if.coef_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_done done=%b run_en=%b ready=%b exp=0/0/1",
               sm_if.done, sm_if.run_en, sm_if.coef_ready);
    end
    for (int k = 0; k < 4; k++) begin
      sm_if.coef_valid = 1'b1;
      sm_if.coef_in    = 20'h11110 + 20'(k);
      step();
      checks++;
      if (sm_if.CLOAD !== 1'b1 || sm_if.CADDR !== 3'(k) || sm_if.CIN !== 20'h11110 + 20'(k)) begin
        failures++;
        $display("FAIL abort_pre k=%0d cload=%b caddr=%0d cin=%0h exp=1/%0d/%0h",
                 k, sm_if.CLOAD, sm_if.CADDR, sm_if.CIN, k, 20'h11110 + 20'(k));
      end
    end
    sm_if.coef_in = 20'hABCDE;
    sm_if.abort   = 1'b1;
    step();
    sm_if.abort = 1'b0;
    checks++;
    if (sm_if.CLOAD !== 1'b0 || sm_if.state_dbg !== ST_IDLE || sm_if.done !== 1'b0 ||
        sm_if.coef_ready !== 1'b0 || sm_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_effect cload=%b state=%0d done=%b ready=%b busy=%b exp=0/0/0/0/0",
               sm_if.CLOAD, sm_if.state_dbg, sm_if.done, sm_if.coef_ready, sm_if.busy);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (sm_if.CLOAD !== 1'b0 || sm_if.coef_ready !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle_valid c=%0d cload=%b ready=%b exp=0/0", c, sm_if.CLOAD, sm_if.coef_ready);
      end
    end
    sm_if.coef_in = 20'h22220;
    sm_if.start   = 1'b1;
    step();
    sm_if.start = 1'b0;
    step();
    checks++;
    if (sm_if.CLOAD !== 1'b1 || sm_if.CADDR !== 3'd0 || sm_if.CIN !== 20'h22220) begin
      failures++;
      $display("FAIL abort_reload cload=%b caddr=%0d cin=%0h exp=1/0/22220",
               sm_if.CLOAD, sm_if.CADDR, sm_if.CIN);
    end
    for (int k = 1; k < 8; k++) begin
      sm_if.coef_in = 20'h22220 + 20'(k);
      step();
    end
    sm_if.coef_valid = 1'b0;
    step();
    checks++;
    if (sm_if.done !== 1'b1 || sm_if.CADDR !== 3'd7 || sm_if.CIN !== 20'h22227) begin
      failures++;
      $display("FAIL abort_reload_done done=%b caddr=%0d cin=%0h exp=1/7/22227",
               sm_if.done, sm_if.CADDR, sm_if.CIN);
    end
  endtask

  task automatic test_start_abort_done();
    sm_if.start = 1'b1;
    sm_if.abort = 1'b1;
    step();
    sm_if.start = 1'b0;
    sm_if.abort = 1'b0;
    checks++;
    if (sm_if.state_dbg !== ST_IDLE || sm_if.done !== 1'b0 || sm_if.run_en !== 1'b0 ||
        sm_if.coef_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_abort state=%0d done=%b run_en=%b ready=%b exp=0/0/0/0",
               sm_if.state_dbg, sm_if.done, sm_if.run_en, sm_if.coef_ready);
    end
    load_small(20'h33330);
    checks++;
    if (sm_if.done !== 1'b1 || sm_if.run_en !== 1'b1) begin
      failures++;
      $display("FAIL second_load_done done=%b run_en=%b exp=1/1", sm_if.done, sm_if.run_en);
    end
    sm_if.start = 1'b1;
    step();
    sm_if.start = 1'b0;
    checks++;
    if (sm_if.coef_ready !== 1'b1 || sm_if.run_en !== 1'b0 || sm_if.done !== 1'b0 ||
        sm_if.state_dbg !== ST_LOAD) begin
      failures++;
      $display("FAIL start_in_done ready=%b run_en=%b done=%b state=%0d exp=1/0/0/1",
               sm_if.coef_ready, sm_if.run_en, sm_if.done, sm_if.state_dbg);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < 5; k++) begin
      sm_if.coef_valid = 1'b1;
      sm_if.coef_in    = 20'h44440 + 20'(k);
      step();
      checks++;
      if (sm_if.CLOAD !== 1'b1 || sm_if.CADDR !== 3'(k)) begin
        failures++;
        $display("FAIL rst_pre k=%0d cload=%b caddr=%0d exp=1/%0d", k, sm_if.CLOAD, sm_if.CADDR, k);
      end
    end
    sm_if.coef_in = 20'h44445;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    sm_if.coef_valid = 1'b0;
    checks++;
    if (sm_if.CLOAD !== 1'b0 || sm_if.CADDR !== 3'd0 || sm_if.CIN !== 20'd0 ||
        sm_if.state_dbg !== ST_IDLE || sm_if.done !== 1'b0 || sm_if.coef_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid cload=%b caddr=%0d cin=%0h state=%0d done=%b ready=%b exp=0/0/0/0/0/0",
               sm_if.CLOAD, sm_if.CADDR, sm_if.CIN, sm_if.state_dbg, sm_if.done, sm_if.coef_ready);
    end
    step();
    checks++;
    if (sm_if.CLOAD !== 1'b0 || sm_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_after cload=%b busy=%b exp=0/0", sm_if.CLOAD, sm_if.busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_bubbled();
    test_abort_mid_load();
    test_start_abort_done();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
